// File: rtl/aux_perf_monitor.sv
// aux_perf_monitor: RUN/HALTED run-control FSM driving en, gating NumCh event counters with sticky overflow flags.
// Latency: en comes straight from the state register; cnt_out is counter[sel] as held before the last edge (1 cycle).
// Backpressure: none; events seen while en==0 are dropped. Macro PERF_SATURATE_EN makes counters saturate instead of wrap.
//
// Port evt carries the per-channel event strobes ("event" is a reserved word in SystemVerilog).
module aux_perf_monitor #(
  parameter int SelBit = 2,
  parameter int CntBit = 32,
  localparam int NumCh = 2 ** SelBit
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              resume,
  input  logic              step_mode,
  input  logic              halt,
  input  logic [NumCh-1:0]  evt,
  input  logic              clr,
  input  logic [SelBit-1:0] sel,
  output logic              en,
  output logic [CntBit-1:0] cnt_out,
  output logic [NumCh-1:0]  ovf
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  localparam logic [CntBit-1:0] CntOne = {{(CntBit-1){1'b0}}, 1'b1};
  localparam logic [CntBit-1:0] CntMax = {CntBit{1'b1}};

  state_e            state_q, state_d;
  logic              resume_q, resume_d;
  logic              resume_rise;
  logic [CntBit-1:0] cnt_q [NumCh];
  logic [CntBit-1:0] cnt_d [NumCh];
  logic [NumCh-1:0]  ovf_q, ovf_d;
  logic [CntBit-1:0] cnt_out_q, cnt_out_d;

  // Resume edge detect; previous sample resets high so a held resume is not an edge.
  always_comb begin
    resume_d    = resume;
    resume_rise = resume & ~resume_q;
  end

  // Run-control state register; reset always lands in RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      resume_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
    end
  end

  // Next state: halt or step mode parks the core; only a resume edge releases it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (halt || step_mode) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (resume_rise) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // FSM output: core enabled exactly while running.
  always_comb begin
    en = (state_q == ST_RUN);
  end

  // Counter update: clear beats increments; an increment from all-ones flags overflow.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      for (int i = 0; i < NumCh; i++) begin
        cnt_d[i] = '0;
      end
      ovf_d = '0;
    end else if (en) begin
      for (int i = 0; i < NumCh; i++) begin
        if (evt[i]) begin
          if (cnt_q[i] == CntMax) begin
            ovf_d[i] = 1'b1;
`ifdef PERF_SATURATE_EN
            cnt_d[i] = CntMax;
`else
            cnt_d[i] = '0;
`endif
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
      end
    end
  end

  // Readout mux samples the pre-edge counter so cnt_out lags sel by one edge.
  always_comb begin
    cnt_out_d = cnt_q[sel];
  end

  // Counter, overflow and readout registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '{default: '0};
      ovf_q     <= '0;
      cnt_out_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      cnt_out_q <= cnt_out_d;
    end
  end

  assign cnt_out = cnt_out_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_aux_perf_monitor.sv
// Testbench for aux_perf_monitor (SelBit=2, CntBit=8).
// Stimulus pushes expected outputs from a behavioural model; a monitor pops and compares every cycle.
// Directed phases cover reset, step mode, halt, wrap/saturate, clear and readout lag; then random traffic.
module tb_aux_perf_monitor;
  localparam int NCH  = 4;
  localparam int CMAX = 255;

  logic       clk = 1'b0;
  logic       rst_n, resume, step_mode, halt, clr;
  logic [3:0] evt;
  logic [1:0] sel;
  logic       en;
  logic [7:0] cnt_out;
  logic [3:0] ovf;

  always #5 clk = ~clk;

  aux_perf_monitor #(.SelBit(2), .CntBit(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .resume    (resume),
    .step_mode (step_mode),
    .halt      (halt),
    .evt       (evt),
    .clr       (clr),
    .sel       (sel),
    .en        (en),
    .cnt_out   (cnt_out),
    .ovf       (ovf)
  );

  typedef struct {
    bit       en;
    int       cnt;
    bit [3:0] ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 0;
  int   en_hi  = 0;

  // Reference model: run flag, event totals per channel, sticky overflow, readout.
  bit       m_run   = 1;
  bit       m_rprev = 1;
  int       m_cnt[NCH];
  bit [3:0] m_ovf   = '0;
  int       m_out   = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    exp_t e;
    bit   was_run;
    bit   rise;
    if (!rst_n) begin
      m_run   = 1;
      m_rprev = 1;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_ovf   = '0;
      m_out   = 0;
    end else begin
      was_run = m_run;
      rise    = resume && !m_rprev;
      m_out   = m_cnt[sel];
      if (clr) begin
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_ovf = '0;
      end else if (was_run) begin
        for (int i = 0; i < NCH; i++) begin
          if (evt[i]) begin
            if (m_cnt[i] + 1 > CMAX) begin
              m_ovf[i] = 1'b1;
`ifdef PERF_SATURATE_EN
              m_cnt[i] = CMAX;
`else
              m_cnt[i] = (m_cnt[i] + 1) % (CMAX + 1);
`endif
            end else begin
              m_cnt[i] = m_cnt[i] + 1;
            end
          end
        end
      end
      m_run   = was_run ? !(halt || step_mode) : rise;
      m_rprev = resume;
    end
    e.en  = m_run;
    e.cnt = m_out;
    e.ovf = m_ovf;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Monitor: the DUT presents outputs every cycle; compare just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        if (!done) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
        end
      end else begin
        e = exp_q.pop_front();
        if (en === 1'b1) en_hi++;
        check("en", int'(en), int'(e.en));
        check("cnt_out", int'(cnt_out), e.cnt);
        check("ovf", int'(ovf), int'(e.ovf));
      end
    end
  end

  initial begin
    foreach (m_cnt[i]) m_cnt[i] = 0;
    rst_n = 0; resume = 1; step_mode = 0; halt = 0; clr = 0; evt = '0; sel = '0;

    // Reset with resume held, then release: stays RUN, zeros everywhere.
    ticks(3);
    rst_n = 1;
    ticks(4);
    check("post_reset_en", int'(en), 1);
    check("post_reset_ovf", int'(ovf), 0);
    resume = 0;
    tick();

    // Step mode: park, clear, then three 4-cycle resume pulses with event[0] held.
    step_mode = 1;
    ticks(2);
    clr = 1;
    tick();
    clr = 0; evt = 4'b0001; sel = 2'd0;
    en_hi = 0;
    for (int p = 0; p < 3; p++) begin
      resume = 1; ticks(4);
      resume = 0; ticks(4);
    end
    check("step_en_cycles", en_hi, 3);
    evt = '0;
    tick();
    check("step_counter0", int'(cnt_out), 3);

    // Halt held through a resume edge: one enabled cycle then halted again.
    step_mode = 0;
    resume = 1; tick();
    resume = 0;
    halt = 1; ticks(5);
    en_hi = 0;
    resume = 1; ticks(4);
    check("halt_resume_en_cycles", en_hi, 1);
    check("halt_resume_halted", int'(en), 0);
    halt = 0; resume = 0;

    // Channel 1 hammered for 257 run cycles.
    clr = 1; tick();
    clr = 0; resume = 1; tick();
    evt = 4'b0010;
    ticks(257);
    evt = '0; sel = 2'd1;
    ticks(2);
`ifdef PERF_SATURATE_EN
    check("ch1_after_257", int'(cnt_out), 255);
`else
    check("ch1_after_257", int'(cnt_out), 1);
`endif
    check("ch1_ovf", int'(ovf[1]), 1);

    // Clear wins over a same-cycle increment.
    evt = 4'b0100; tick();
    clr = 1; tick();
    clr = 0; evt = '0; sel = 2'd2;
    ticks(2);
    check("clr_ch2", int'(cnt_out), 0);
    check("clr_ovf", int'(ovf), 0);

    // Distinct preloads then step sel to observe the one-cycle readout lag.
    for (int j = 0; j < 12; j++) begin
      for (int i = 0; i < NCH; i++) evt[i] = (j < i * 3 + 1);
      tick();
    end
    evt = '0;
    for (int s = 0; s < NCH; s++) begin
      sel = 2'(s);
      tick();
      check("sel_lag", int'(cnt_out), s * 3 + 1);
    end

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      clr   = ($urandom_range(0, 39) == 0);
      halt  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 49) == 0) step_mode = ~step_mode;
      if ($urandom_range(0, 2) == 0) resume = ~resume;
      evt = 4'($urandom);
      sel = 2'($urandom);
      tick();
    end

    done = 1;
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aux_perf_monitor.md
AUX_PERF_MONITOR -- requirements
Module: aux_perf_monitor

Interface
REQ-001 SelBit, default 2, channel-select width; channel count NumCh SHALL be 2**SelBit.
REQ-002 CntBit, default 32, per-channel counter width, legal range 8..64.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 resume  input  1  run request level, already synchronised to clk.
REQ-006 step_mode  input  1  1 = single-step execution, 0 = free run.
REQ-007 halt  input  1  core halt request.
REQ-008 event  input  NumCh  per-channel event strobes; event[i] counts into channel i.
REQ-009 clr  input  1  clear all counters and overflow flags.
REQ-010 sel  input  SelBit  channel index for cnt_out.
REQ-011 en  output  1  core enable.
REQ-012 cnt_out  output  CntBit  registered value of channel sel.
REQ-013 ovf  output  NumCh  sticky per-channel overflow flags.

Function
REQ-014 The run-control FSM SHALL have two states, RUN and HALTED; en SHALL be 1 exactly when the state is RUN.
REQ-015 A resume rising edge SHALL be detected as resume==1 with a registered previous sample resume_q==0.
REQ-016 RUN SHALL go to HALTED when halt==1 or step_mode==1; otherwise it SHALL stay in RUN.
REQ-017 HALTED SHALL go to RUN on a resume rising edge, regardless of halt, and SHALL otherwise stay in HALTED.
REQ-018 In step mode, each resume rising edge SHALL therefore produce exactly one en==1 cycle.
REQ-019 In RUN, halt==1 and a resume edge in the same cycle SHALL result in HALTED (halt wins).
REQ-020 Counter i SHALL increment by 1 in a cycle where en==1 and event[i]==1.
REQ-021 clr==1 SHALL zero all counters and ovf on the next edge, overriding any same-cycle increment; the FSM SHALL be unaffected.
REQ-022 Without saturation (REQ-028), an increment from all-ones SHALL wrap to 0 and set ovf[i]; ovf[i] SHALL remain set until clr or reset.
REQ-023 cnt_out SHALL equal counter[sel] as sampled at the previous edge (1-cycle latency); a change on sel SHALL be reflected after exactly one edge.
REQ-024 Events arriving while en==0 SHALL be ignored.

Reset
REQ-025 When rst_n==0 at an edge, the state SHALL become RUN (en=1), and all counters, ovf and cnt_out SHALL become 0.
REQ-026 resume_q SHALL reset to 1, so a resume held through reset produces no edge.
REQ-027 Reset SHALL take priority over clr, halt, resume and events; reset during HALTED SHALL return the FSM to RUN.

Configuration
REQ-028 With PERF_SATURATE_EN defined, a counter at all-ones SHALL hold at all-ones on a further increment and set ovf[i]; without it, counters SHALL wrap per REQ-022.

Verification
REQ-029 Reset with resume=1 held, then release rst_n -> en=1, cnt_out=0, ovf=0, and no spurious state change.
REQ-030 step_mode=1 with event[0]=1 held, then three resume pulses of 4 cycles each -> exactly three en==1 cycles and counter0=3.
REQ-031 halt=1 in RUN for 5 cycles, then a resume edge with halt still 1 -> one en cycle, then HALTED again.
REQ-032 CntBit=8, event[1]=1 for 257 run cycles -> counter1=1 and ovf[1]=1 (wrap); with PERF_SATURATE_EN -> counter1=255 and ovf[1]=1.
REQ-033 clr=1 in the same cycle as event[2]=1 with en=1 -> counter2=0 and ovf=0 next cycle.
REQ-034 Counters preloaded to distinct values, sel stepped 0..3 -> cnt_out tracks each channel with exactly 1-cycle lag.
